// File: rtl/bp_update_queue_if.sv
// Bundle of prediction-record, resolution and training signals between the
// predictor pipeline and bp_update_queue.
interface bp_update_queue_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = 32,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic             pred_valid_i;
    logic [IDX_W-1:0] pred_idx_i;
    logic             pred_taken_i;
    logic             resolve_valid_i;
    logic             resolve_taken_i;
    logic             flush_i;

    logic             update_en_o;
    logic [IDX_W-1:0] update_idx_o;
    logic             br_result_o;
    logic             correct_o;
    logic             full_o;
    logic             empty_o;
    logic [OCC_W-1:0] count_o;
    logic             overflow_o;
    logic             underflow_o;
    logic [CNT_W-1:0] resolved_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    modport master (
        output pred_valid_i, pred_idx_i, pred_taken_i,
               resolve_valid_i, resolve_taken_i, flush_i,
        input  update_en_o, update_idx_o, br_result_o, correct_o,
               full_o, empty_o, count_o, overflow_o, underflow_o,
               resolved_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  pred_valid_i, pred_idx_i, pred_taken_i,
               resolve_valid_i, resolve_taken_i, flush_i,
        output update_en_o, update_idx_o, br_result_o, correct_o,
               full_o, empty_o, count_o, overflow_o, underflow_o,
               resolved_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/bp_update_queue.sv
// In-flight branch prediction FIFO: records predictions, pops them in order on
// resolution to drive predictor training, and keeps saturating statistics.
module bp_update_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    bp_update_queue_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [IDX_W-1:0] idx_mem [DEPTH];
    logic [DEPTH-1:0] taken_mem;

    logic [PTR_W-1:0] wptr_reg, wptr_next;
    logic [PTR_W-1:0] rptr_reg, rptr_next;
    logic [OCC_W-1:0] count_reg, count_next;
    logic             full_reg, empty_reg;
    logic             update_en_reg;
    logic [IDX_W-1:0] update_idx_reg;
    logic             br_result_reg, correct_reg;
    logic             overflow_reg, underflow_reg;
    logic [CNT_W-1:0] resolved_reg, resolved_next;
    logic [CNT_W-1:0] mispred_reg, mispred_next;

    logic do_pop, do_push, head_taken, head_correct;

    // A pop frees a slot in the same cycle, so a push is accepted when full if paired with a pop.
    assign do_pop       = bus.resolve_valid_i && !empty_reg;
    assign do_push      = bus.pred_valid_i && (!full_reg || do_pop) && !bus.flush_i;
    assign head_taken   = taken_mem[rptr_reg];
    assign head_correct = (head_taken == bus.resolve_taken_i);

    always_comb begin
        wptr_next     = wptr_reg;
        rptr_next     = rptr_reg;
        count_next    = count_reg;
        resolved_next = resolved_reg;
        mispred_next  = mispred_reg;

        if (do_push) wptr_next = wptr_reg + 1'b1;
        if (do_pop)  rptr_next = rptr_reg + 1'b1;

        if (do_push && !do_pop)
            count_next = count_reg + 1'b1;
        else if (!do_push && do_pop)
            count_next = count_reg - 1'b1;

        // Flush takes effect after the same-cycle pop has been serviced.
        if (bus.flush_i) begin
            wptr_next  = '0;
            rptr_next  = '0;
            count_next = '0;
        end

        if (do_pop) begin
            if (resolved_reg != '1) resolved_next = resolved_reg + 1'b1;
            if (!head_correct && mispred_reg != '1) mispred_next = mispred_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            idx_mem[wptr_reg]   <= bus.pred_idx_i;
            taken_mem[wptr_reg] <= bus.pred_taken_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_reg       <= '0;
            rptr_reg       <= '0;
            count_reg      <= '0;
            full_reg       <= 1'b0;
            empty_reg      <= 1'b1;
            update_en_reg  <= 1'b0;
            update_idx_reg <= '0;
            br_result_reg  <= 1'b0;
            correct_reg    <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
            resolved_reg   <= '0;
            mispred_reg    <= '0;
        end else begin
            wptr_reg      <= wptr_next;
            rptr_reg      <= rptr_next;
            count_reg     <= count_next;
            full_reg      <= (count_next == OCC_W'(DEPTH));
            empty_reg     <= (count_next == '0);
            update_en_reg <= do_pop;
            resolved_reg  <= resolved_next;
            mispred_reg   <= mispred_next;
            if (do_pop) begin
                update_idx_reg <= idx_mem[rptr_reg];
                br_result_reg  <= bus.resolve_taken_i;
                correct_reg    <= head_correct;
            end
            if (bus.pred_valid_i && full_reg && !do_pop && !bus.flush_i)
                overflow_reg <= 1'b1;
            if (bus.resolve_valid_i && empty_reg)
                underflow_reg <= 1'b1;
        end
    end

    assign bus.update_en_o    = update_en_reg;
    assign bus.update_idx_o   = update_idx_reg;
    assign bus.br_result_o    = br_result_reg;
    assign bus.correct_o      = correct_reg;
    assign bus.full_o         = full_reg;
    assign bus.empty_o        = empty_reg;
    assign bus.count_o        = count_reg;
    assign bus.overflow_o     = overflow_reg;
    assign bus.underflow_o    = underflow_reg;
    assign bus.resolved_cnt_o = resolved_reg;
    assign bus.mispred_cnt_o  = mispred_reg;
endmodule

// File: tb/tb_bp_update_queue.sv
// Self-checking bench for bp_update_queue: directed table, corner sequences and
// random traffic against a queue-based reference model.
module tb_bp_update_queue;
    localparam int DEPTH = 8;
    localparam int IDX_W = 32;
    localparam int CNT_W = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bp_update_queue_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();
    bp_update_queue_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(2))     bus2 ();

    bp_update_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus));
    bp_update_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .bus(bus2));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of in-flight predictions.
    typedef struct packed { logic [IDX_W-1:0] idx; logic taken; } ent_t;
    ent_t             mq[$];
    logic             m_en, m_res, m_cor, m_ovf, m_unf;
    logic [IDX_W-1:0] m_idx;
    int               m_resolved, m_mispred;

    function automatic void model_reset();
        mq.delete();
        m_en = 0; m_res = 0; m_cor = 0; m_ovf = 0; m_unf = 0;
        m_idx = '0; m_resolved = 0; m_mispred = 0;
    endfunction

    function automatic void model_step(input logic pv, input logic [IDX_W-1:0] pidx,
                                       input logic pt, input logic rv, input logic rt,
                                       input logic fl);
        ent_t e;
        m_en = 0;
        if (rv && mq.size() > 0) begin
            e     = mq.pop_front();
            m_en  = 1;
            m_idx = e.idx;
            m_res = rt;
            m_cor = (e.taken == rt);
            if (m_resolved < CNT_MAX) m_resolved++;
            if (!m_cor && m_mispred < CNT_MAX) m_mispred++;
        end else if (rv) begin
            m_unf = 1;
        end
        if (fl) mq.delete();
        else if (pv) begin
            if (mq.size() < DEPTH) mq.push_back({pidx, pt});
            else m_ovf = 1;
        end
    endfunction

    task automatic check_model();
        chk("update_en",   bus.update_en_o,    m_en);
        chk("update_idx",  bus.update_idx_o,   m_idx);
        chk("br_result",   bus.br_result_o,    m_res);
        chk("correct",     bus.correct_o,      m_cor);
        chk("count",       bus.count_o,        mq.size());
        chk("full",        bus.full_o,         mq.size() == DEPTH);
        chk("empty",       bus.empty_o,        mq.size() == 0);
        chk("overflow",    bus.overflow_o,     m_ovf);
        chk("underflow",   bus.underflow_o,    m_unf);
        chk("resolved",    bus.resolved_cnt_o, m_resolved);
        chk("mispred",     bus.mispred_cnt_o,  m_mispred);
    endtask

    // One clock of stimulus; called just after a rising edge, checks just after the next.
    task automatic cycle(input logic pv, input logic [IDX_W-1:0] pidx, input logic pt,
                         input logic rv, input logic rt, input logic fl);
        bus.pred_valid_i    = pv;
        bus.pred_idx_i      = pidx;
        bus.pred_taken_i    = pt;
        bus.resolve_valid_i = rv;
        bus.resolve_taken_i = rt;
        bus.flush_i         = fl;
        model_step(pv, pidx, pt, rv, rt, fl);
        @(posedge clk);
        #1;
        bus.pred_valid_i    = 0;
        bus.resolve_valid_i = 0;
        bus.flush_i         = 0;
        check_model();
        $display("t=%0t push=%0b idx=%0h pt=%0b res=%0b rt=%0b fl=%0b -> en=%0b uidx=%0h cor=%0b cnt=%0d",
                 $time, pv, pidx, pt, rv, rt, fl, bus.update_en_o, bus.update_idx_o,
                 bus.correct_o, bus.count_o);
    endtask

    typedef struct {
        logic pv; logic [IDX_W-1:0] pidx; logic pt; logic rv; logic rt; logic fl;
        logic e_en; logic [IDX_W-1:0] e_idx; logic e_res; logic e_cor;
        int e_cnt; int e_resolved; int e_mispred;
    } vec_t;
    vec_t tbl[6];

    initial begin
        //            pv pidx  pt rv rt fl  en  idx   res cor cnt rsl msp
        tbl[0] = '{1, 'h10, 1, 0, 0, 0,  0, 'h00, 0,  0,  1,  0,  0};
        tbl[1] = '{0, 'h00, 0, 0, 0, 0,  0, 'h00, 0,  0,  1,  0,  0};
        tbl[2] = '{0, 'h00, 0, 1, 1, 0,  1, 'h10, 1,  1,  0,  1,  0};
        tbl[3] = '{1, 'h20, 0, 0, 0, 0,  0, 'h10, 1,  1,  1,  1,  0};
        tbl[4] = '{0, 'h00, 0, 1, 1, 0,  1, 'h20, 1,  0,  0,  2,  1};
        tbl[5] = '{0, 'h00, 0, 0, 0, 0,  0, 'h20, 1,  0,  0,  2,  1};

        bus.pred_valid_i = 0; bus.pred_idx_i = '0; bus.pred_taken_i = 0;
        bus.resolve_valid_i = 0; bus.resolve_taken_i = 0; bus.flush_i = 0;
        bus2.pred_valid_i = 0; bus2.pred_idx_i = '0; bus2.pred_taken_i = 0;
        bus2.resolve_valid_i = 0; bus2.resolve_taken_i = 0; bus2.flush_i = 0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_update_en", bus.update_en_o, 0);
        chk("rst_empty",     bus.empty_o, 1);
        chk("rst_full",      bus.full_o, 0);
        chk("rst_count",     bus.count_o, 0);
        rst = 0;

        // Directed basic training sequence.
        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].pv, tbl[i].pidx, tbl[i].pt, tbl[i].rv, tbl[i].rt, tbl[i].fl);
            chk("tbl_en",       bus.update_en_o,    tbl[i].e_en);
            chk("tbl_idx",      bus.update_idx_o,   tbl[i].e_idx);
            chk("tbl_result",   bus.br_result_o,    tbl[i].e_res);
            chk("tbl_correct",  bus.correct_o,      tbl[i].e_cor);
            chk("tbl_count",    bus.count_o,        tbl[i].e_cnt);
            chk("tbl_resolved", bus.resolved_cnt_o, tbl[i].e_resolved);
            chk("tbl_mispred",  bus.mispred_cnt_o,  tbl[i].e_mispred);
        end

        // Fill, push+pop while full, overflow, then drain in order.
        for (int i = 0; i < DEPTH; i++) cycle(1, IDX_W'(i), i[0], 0, 0, 0);
        chk("fill_full",  bus.full_o, 1);
        chk("fill_count", bus.count_o, 8);
        cycle(1, 'h99, 1, 1, 0, 0);
        chk("pp_full_count", bus.count_o, 8);
        chk("pp_full_ovf",   bus.overflow_o, 0);
        chk("pp_full_en",    bus.update_en_o, 1);
        chk("pp_full_idx",   bus.update_idx_o, 0);
        cycle(1, 'h8, 0, 0, 0, 0);
        chk("ovf_set",   bus.overflow_o, 1);
        chk("ovf_count", bus.count_o, 8);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, '0, 0, 1, 1, 0);
            chk("drain_en",  bus.update_en_o, 1);
            chk("drain_idx", bus.update_idx_o, (i < DEPTH - 1) ? (i + 1) : 'h99);
        end
        chk("drain_empty", bus.empty_o, 1);

        // Resolve while empty.
        cycle(0, '0, 0, 1, 0, 0);
        chk("unf_en",  bus.update_en_o, 0);
        chk("unf_set", bus.underflow_o, 1);

        // Flush with a same-cycle resolve.
        for (int i = 0; i < 3; i++) cycle(1, IDX_W'('h30 + i), 1, 0, 0, 0);
        cycle(1, 'h77, 0, 1, 1, 1);
        chk("flush_en",    bus.update_en_o, 1);
        chk("flush_idx",   bus.update_idx_o, 'h30);
        chk("flush_count", bus.count_o, 0);
        cycle(0, '0, 0, 1, 1, 0);
        chk("flush_after_en", bus.update_en_o, 0);
        chk("flush_unf",      bus.underflow_o, 1);

        // Asynchronous reset between edges with entries in flight.
        for (int i = 0; i < 5; i++) cycle(1, IDX_W'('h50 + i), 0, 0, 0, 0);
        cycle(0, '0, 0, 1, 1, 0);
        #2 rst = 1;
        #1;
        chk("arst_en",       bus.update_en_o, 0);
        chk("arst_idx",      bus.update_idx_o, 0);
        chk("arst_result",   bus.br_result_o, 0);
        chk("arst_correct",  bus.correct_o, 0);
        chk("arst_count",    bus.count_o, 0);
        chk("arst_empty",    bus.empty_o, 1);
        chk("arst_full",     bus.full_o, 0);
        chk("arst_ovf",      bus.overflow_o, 0);
        chk("arst_unf",      bus.underflow_o, 0);
        chk("arst_resolved", bus.resolved_cnt_o, 0);
        chk("arst_mispred",  bus.mispred_cnt_o, 0);
        @(negedge clk);
        rst = 0;
        model_reset();
        cycle(0, '0, 0, 0, 0, 0);
        cycle(0, '0, 0, 0, 0, 0);

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) < 55, $urandom, 1'($urandom),
                  $urandom_range(0, 99) < 45, 1'($urandom),
                  $urandom_range(0, 99) < 3);
        end

        // Saturation of 2-bit statistics counters.
        for (int k = 0; k < 5; k++) begin
            bus2.pred_valid_i = 1; bus2.pred_idx_i = IDX_W'(k); bus2.pred_taken_i = 0;
            @(posedge clk); #1;
            bus2.pred_valid_i = 0;
            bus2.resolve_valid_i = 1; bus2.resolve_taken_i = 1;
            @(posedge clk); #1;
            bus2.resolve_valid_i = 0;
            $display("t=%0t sat pass %0d -> mispred=%0d resolved=%0d",
                     $time, k, bus2.mispred_cnt_o, bus2.resolved_cnt_o);
            if (k == 1) chk("sat_mispred_2", bus2.mispred_cnt_o, 2);
        end
        chk("sat_mispred",  bus2.mispred_cnt_o, 3);
        chk("sat_resolved", bus2.resolved_cnt_o, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bp_update_queue.md
Name: bp_update_queue

Overview:
- Sits directly downstream of tage_predictor.
- Records each prediction (index and predicted direction) in a FIFO while the branch is in flight.
- On in-order branch resolution, pops the oldest entry and drives the predictor's training inputs: idx_i, br_result_i, correct_i, update_en_i.
- Also keeps saturating prediction/misprediction statistics for performance debug.

Parameters:
- DEPTH, 8: max in-flight branches; power of two, >= 2.
- IDX_W, 32: width of the predictor index.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- pred_valid_i  in  1  a prediction was made this cycle; push.
- pred_idx_i  in  IDX_W  index presented to the predictor.
- pred_taken_i  in  1  predictor's prediction_o for pred_idx_i.
- resolve_valid_i  in  1  oldest in-flight branch resolved this cycle; pop.
- resolve_taken_i  in  1  actual outcome (1 = taken).
- flush_i  in  1  pipeline flush; discard all in-flight entries.
- update_en_o  in/out: out  1  one-cycle training strobe to predictor (update_en_i).
- update_idx_o  out  IDX_W  index to train (idx_i).
- br_result_o  out  1  actual outcome (br_result_i).
- correct_o  out  1  prediction matched outcome (correct_i).
- full_o  out  1  occupancy == DEPTH.
- empty_o  out  1  occupancy == 0.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- overflow_o  out  1  sticky: push attempted while full.
- underflow_o  out  1  sticky: resolve attempted while empty.
- resolved_cnt_o  out  CNT_W  saturating count of resolved branches.
- mispred_cnt_o  out  CNT_W  saturating count of mispredictions.

Behaviour:
- Reset (async, rst_i=1):
  - Pointers and count cleared.
  - update_en_o, update_idx_o, br_result_o, correct_o, overflow_o, underflow_o and both counters = 0.
  - empty_o = 1, full_o = 0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all entries immediately; no update strobe follows.
- Storage: circular buffer of DEPTH entries {idx, taken}. Read/write pointers are $clog2(DEPTH) bits and wrap naturally. count tracked separately.
- full_o, empty_o and count_o are registered state; they reflect occupancy after the previous edge.
- Push: pred_valid_i && (!full || pop this cycle) writes the entry at wptr; wptr increments.
- Push while full with no same-cycle pop: entry dropped, overflow_o set (sticky until reset).
- Pop: resolve_valid_i && !empty reads the head entry. The next edge registers:
  - update_en_o = 1
  - update_idx_o = entry.idx
  - br_result_o = resolve_taken_i
  - correct_o = (entry.taken == resolve_taken_i)
  - rptr increments.
- Latency: resolve in cycle N -> update_en_o high in cycle N+1, for exactly one cycle per pop.
- update_idx_o, br_result_o and correct_o hold their last values when update_en_o = 0.
- Resolve while empty: no strobe, underflow_o set (sticky). A push in the same cycle is not bypassed; it is pushed normally.
- Simultaneous push and pop with 0 < count < DEPTH: both occur, count unchanged.
- Simultaneous push and pop when full: both occur (the pop frees the slot), count stays DEPTH, no overflow.
- Flush: flush_i = 1 clears pointers and count at the next edge.
  - A same-cycle valid resolve is still processed first; its update strobe is emitted.
  - A same-cycle push is discarded and does not set overflow.
- Statistics, on each pop:
  - resolved_cnt_o += 1.
  - mispred_cnt_o += 1 if the prediction was wrong.
  - Both saturate at 2^CNT_W-1 and do not wrap.
  - Cleared only by reset.

Test Plan:
- Reset then push idx=0x10 taken=1; resolve taken=1 two cycles later -> next cycle update_en_o=1, update_idx_o=0x10, br_result_o=1, correct_o=1; resolved_cnt_o=1, mispred_cnt_o=0.
- Push idx=0x20 taken=0; resolve taken=1 -> correct_o=0, br_result_o=1, mispred_cnt_o=1; update_en_o high exactly one cycle.
- Push 8 entries idx 0..7 (DEPTH=8) -> full_o=1, count_o=8. Push a 9th -> overflow_o=1, count stays 8. Push+resolve the same cycle -> count_o=8, no overflow, strobe idx=0. Then 8 resolves -> idx 1..7 then the pushed entry, in order; empty_o=1.
- Resolve with queue empty -> no update_en_o, underflow_o=1. Stays 1 after later normal traffic until rst_i.
- Push 3 entries, then flush_i together with resolve -> strobe for the oldest idx only; count_o=0 next cycle; a later resolve gives underflow.
- Push 5 entries, assert rst_i asynchronously between edges -> outputs zero immediately, empty_o=1, no strobe after release. With CNT_W=2, 5 mispredicted resolves -> mispred_cnt_o saturates at 3.
